// File: rtl/sramlike_to_axi.sv
// SRAM-like request port to single-beat AXI3/AXI4 master, one transaction outstanding.
// Optional SRAMLIKE_AXI_POSTED_WRITE_EN: write data_ok fires once AW/W complete, before B.
// resetn asserts asynchronously; its release is expected to be synchronous to clk.
module sramlike_to_axi #(
    parameter int ID   = 0,
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            resetn,
    // SRAM-like slave side
    input  logic [31:0]     addr,
    input  logic [3:0]      ben,
    input  logic            wr,
    input  logic [31:0]     din,
    output logic            addr_ok,
    output logic            data_ok,
    output logic [31:0]     dout,
    // AXI read address
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    // AXI read data
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AXI write address
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    // AXI write data
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // AXI write response
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_REQ = 3'd3,
        WR_B   = 3'd4,
        RESP   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  size_q,  size_d;
    logic [3:0]  ben_q,   ben_d;
    logic [31:0] din_q,   din_d;
    logic [31:0] dout_q,  dout_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
    logic        post_ok_q, post_ok_d;
`endif

    // Contiguous halves and single bytes get a narrow size; anything else is a full word.
    function automatic logic [2:0] req_size(input logic [3:0] b);
        case (b)
            4'b0011, 4'b1100:                   req_size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 3'd0;
            default:                            req_size = 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] req_low(input logic [3:0] b);
        case (b)
            4'b1100, 4'b0100: req_low = 2'b10;
            4'b0010:          req_low = 2'b01;
            4'b1000:          req_low = 2'b11;
            default:          req_low = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            ben_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
            post_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            ben_q     <= ben_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
            post_ok_q <= post_ok_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        ben_d     = ben_q;
        din_d     = din_q;
        dout_d    = dout_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
        post_ok_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ben != 4'b0000) begin
                    addr_d    = {addr[31:2], req_low(ben)};
                    size_d    = req_size(ben);
                    ben_d     = ben;
                    din_d     = din;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                if (arready) state_d = RD_R;
            end
            RD_R: begin
                if (rvalid) begin
                    dout_d  = rdata;
                    state_d = RESP;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave only once both have handshaken.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q  | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
                    post_ok_d = 1'b1;
`endif
                end
            end
            WR_B: begin
                if (bvalid) begin
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
                    state_d = IDLE;
`else
                    state_d = RESP;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by resetn so the upstream never sees an accept while reset is held.
    assign addr_ok = resetn && (state_q == IDLE) && (ben != 4'b0000);
`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
    assign data_ok = (state_q == RESP) || post_ok_q;
`else
    assign data_ok = (state_q == RESP);
`endif
    assign dout    = dout_q;

    assign arid    = ID_W'(ID);
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = size_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (state_q == RD_AR);
    assign rready  = (state_q == RD_R);

    assign awid    = ID_W'(ID);
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (state_q == WR_REQ) && !aw_done_q;

    assign wid     = ID_W'(ID);
    assign wdata   = din_q;
    assign wstrb   = ben_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign bready  = (state_q == WR_B);

    // Response IDs, error codes and rlast carry no information for single-beat traffic.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sramlike_to_axi.sv
// Bench for sramlike_to_axi: vector table plus corner sequences, checked through a scoreboard.
module tb_sramlike_to_axi;

`ifdef SRAMLIKE_AXI_POSTED_WRITE_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    logic        clk, resetn;
    logic [31:0] addr, din, dout;
    logic [3:0]  ben;
    logic        wr, addr_ok, data_ok;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    sramlike_to_axi #(.ID(0), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .ben(ben), .wr(wr), .din(din),
        .addr_ok(addr_ok), .data_ok(data_ok), .dout(dout),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- AXI slave model with programmable delays ----------------
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] rdata_v = 32'h0;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, b_pend, aw_got, w_got;
    logic [31:0] lg_addr, lg_data;
    logic [2:0]  lg_size;
    logic [3:0]  lg_strb;
    logic [7:0]  lg_len;
    logic [1:0]  lg_burst;
    logic        lg_last;
    logic        aw_hs, w_hs;

    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign rvalid  = r_pend && (r_cnt >= r_dly);
    assign rdata   = rvalid ? rdata_v : 32'h0;
    assign rid     = 4'h0;
    assign rresp   = 2'b10;
    assign rlast   = 1'b1;
    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign bvalid  = b_pend && (b_cnt >= b_dly);
    assign bid     = 4'h0;
    assign bresp   = 2'b10;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (r_pend) begin
                if (rvalid && rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (arvalid && arready) begin
                r_pend <= 1'b1; r_cnt <= 0;
                lg_addr <= araddr; lg_size <= arsize; lg_len <= arlen; lg_burst <= arburst;
            end
            if (b_pend) begin
                if (bvalid && bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end
            if (aw_hs) begin
                lg_addr <= awaddr; lg_size <= awsize; lg_len <= awlen; lg_burst <= awburst;
            end
            if (w_hs) begin
                lg_strb <= wstrb; lg_data <= wdata; lg_last <= wlast;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        rd;
        logic [31:0] dout;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  ben;
        logic        wr;
        logic [31:0] din;
        logic [31:0] rdata;
        int          ad, rd, awd, wd, bd;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic int lat_of(input vec_t v);
        int mx;
        mx = (v.awd > v.wd) ? v.awd : v.wd;
        if (!v.wr) return 3 + v.ad + v.rd;
        return POST ? (2 + mx) : (3 + mx + v.bd);
    endfunction

    always @(negedge clk) begin
        if (resetn && data_ok) begin
            if (sb.size() == 0) begin
                chk("unexpected_data_ok", 64'(1'b1), 64'(1'b0));
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
                chk("axi_addr", 64'(lg_addr), 64'(mon_e.addr));
                chk("axi_size", 64'(lg_size), 64'(mon_e.size));
                chk("axi_len_burst", 64'({lg_len, lg_burst}), 64'({8'd0, 2'b01}));
                if (mon_e.rd) begin
                    chk("dout", 64'(dout), 64'(mon_e.dout));
                end else begin
                    chk("wstrb", 64'(lg_strb), 64'(mon_e.strb));
                    chk("wdata", 64'(lg_data), 64'(mon_e.wdata));
                    chk("wlast", 64'(lg_last), 64'(1'b1));
                end
            end
        end
    end

    // Presents v, waits (bounded) for addr_ok, then queues the expected completion.
    task automatic issue(input vec_t v, input bit hold, output int waited);
        exp_t e;
        int   w;
        @(negedge clk);
        addr = v.addr; ben = v.ben; wr = v.wr; din = v.din;
        w = 0;
        #1;
        while (!addr_ok && w < 60) begin
            @(negedge clk); #1; w++;
        end
        waited = w;
        if (!addr_ok) begin
            chk("accept_timeout", 64'(addr_ok), 64'(1'b1));
            return;
        end
        ar_dly = v.ad; r_dly = v.rd; aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd;
        rdata_v = v.rdata;
        e.rd = !v.wr; e.dout = v.rdata; e.addr = v.exp_addr; e.size = v.exp_size;
        e.strb = v.ben; e.wdata = v.din; e.cyc = cyc + lat_of(v);
        sb.push_back(e);
        @(posedge clk); #1;
        if (!hold) ben = 4'b0000;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    vec_t vt[12];
    vec_t v;
    int   wt;
    bit   seen;
    int   k;
    int   dok_at, idle_at;

    initial begin
        //        addr          ben      wr    din           rdata         ad rd aw w  b  exp_addr      size
        vt[0]  = '{32'h1FC0_0004, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h1FC0_0004, 3'd2};
        vt[1]  = '{32'hBFAF_F002, 4'b0100, 1'b1, 32'h00AB_0000, 32'h0,        0, 0, 0, 0, 2, 32'hBFAF_F002, 3'd0};
        vt[2]  = '{32'h8000_1000, 4'b0011, 1'b1, 32'h1234_5678, 32'h0,        0, 0, 0, 0, 0, 32'h8000_1000, 3'd1};
        vt[3]  = '{32'h8000_1003, 4'b1100, 1'b1, 32'h9ABC_0000, 32'h0,        0, 0, 0, 0, 0, 32'h8000_1002, 3'd1};
        vt[4]  = '{32'h8000_2003, 4'b1000, 1'b1, 32'h7700_0000, 32'h0,        0, 0, 0, 0, 0, 32'h8000_2003, 3'd0};
        vt[5]  = '{32'h8000_2002, 4'b0001, 1'b1, 32'h0000_0011, 32'h0,        0, 0, 0, 0, 0, 32'h8000_2000, 3'd0};
        vt[6]  = '{32'h8000_2000, 4'b0010, 1'b1, 32'h0000_2200, 32'h0,        0, 0, 0, 0, 0, 32'h8000_2001, 3'd0};
        vt[7]  = '{32'h8000_3003, 4'b0111, 1'b1, 32'h00C0_FFEE, 32'h0,        0, 0, 0, 0, 0, 32'h8000_3000, 3'd2};
        vt[8]  = '{32'h8000_3001, 4'b1110, 1'b1, 32'hBEEF_0100, 32'h0,        0, 0, 0, 0, 1, 32'h8000_3000, 3'd2};
        vt[9]  = '{32'h0000_0010, 4'b1000, 1'b0, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'h0000_0013, 3'd0};
        vt[10] = '{32'h9000_0004, 4'b1111, 1'b1, 32'h5555_AAAA, 32'h0,        0, 0, 0, 2, 0, 32'h9000_0004, 3'd2};
        vt[11] = '{32'h1234_5678, 4'b1111, 1'b0, 32'h0,        32'h0102_0304, 1, 2, 0, 0, 0, 32'h1234_5678, 3'd2};

        resetn = 1'b0; addr = 32'h1FC0_0000; ben = 4'b1111; wr = 1'b0; din = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr_ok", 64'(addr_ok), 64'(1'b0));
        chk("rst_data_ok", 64'(data_ok), 64'(1'b0));
        chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'(5'b0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_addrs", 64'({araddr, awaddr}), 64'(0));
        chk("ar_consts", 64'({arid, arlen, arlock, arcache, arprot, arburst}), 64'(2'b01));
        chk("aw_consts", 64'({awid, awlen, awlock, awcache, awprot, awburst}), 64'(2'b01));
        chk("w_consts", 64'({wid, wlast}), 64'(1'b1));
        ben = 4'b0000;
        @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vt[i], 1'b0, wt);
            wait_done();
        end

        // Skewed write: W handshakes at once, AW three cycles later.
        v = '{32'h8000_4005, 4'b0110, 1'b1, 32'hA5A5_5A5A, 32'h0, 0, 0, 3, 0, 0, 32'h8000_4004, 3'd2};
        issue(v, 1'b0, wt);
        @(negedge clk); #1;
        chk("skew_t1", 64'({awvalid, wvalid, bready}), 64'(3'b110));
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk); #1;
            chk("skew_wait", 64'({awvalid, wvalid, bready}), 64'(3'b100));
        end
        @(negedge clk); #1;
        chk("skew_t5", 64'({awvalid, wvalid, bready}), 64'(3'b001));
        wait_done();

        // Backpressure: second read held upstream throughout the first.
        v = '{32'h1FC0_0010, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D, 5, 4, 0, 0, 0, 32'h1FC0_0010, 3'd2};
        issue(v, 1'b1, wt);
        addr = 32'h1FC0_0020;
        seen = 1'b0; k = 0;
        while (!seen && k < 30) begin
            @(negedge clk); #1; k++;
            chk("busy_addr_ok", 64'(addr_ok), 64'(1'b0));
            seen = data_ok;
        end
        chk("bp_data_ok_seen", 64'(seen), 64'(1'b1));
        v = '{32'h1FC0_0020, 4'b1111, 1'b0, 32'h0, 32'h600D_CAFE, 0, 0, 0, 0, 0, 32'h1FC0_0020, 3'd2};
        issue(v, 1'b0, wt);
        chk("accept_after_resp", 64'(wt), 64'(0));
        wait_done();

        // Asynchronous reset while waiting for R.
        v = '{32'h0040_0000, 4'b1111, 1'b0, 32'h0, 32'h1111_2222, 0, 20, 0, 0, 0, 32'h0040_0000, 3'd2};
        issue(v, 1'b0, wt);
        @(negedge clk); #1;
        chk("pre_rst_arvalid", 64'(arvalid), 64'(1'b1));
        @(negedge clk); #1;
        chk("pre_rst_rready", 64'(rready), 64'(1'b1));
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_valids", 64'({arvalid, rready, data_ok, awvalid, wvalid, bready}), 64'(6'b0));
        chk("async_rst_dout", 64'(dout), 64'(0));
        sb.delete();
        @(negedge clk); resetn = 1'b1;
        v = '{32'h0040_0008, 4'b1111, 1'b0, 32'h0, 32'h3333_4444, 0, 0, 0, 0, 0, 32'h0040_0008, 3'd2};
        issue(v, 1'b0, wt);
        chk("post_rst_accept", 64'(wt), 64'(0));
        wait_done();

        // Slow B with the request held: data_ok timing and addr_ok hold-off.
        v = '{32'h8000_5000, 4'b1111, 1'b1, 32'h0F0F_F0F0, 32'h0, 0, 0, 0, 0, 6, 32'h8000_5000, 3'd2};
        dok_at  = POST ? 2 : 9;
        idle_at = POST ? 9 : 10;
        issue(v, 1'b1, wt);
        for (int t = 1; t < idle_at; t++) begin
            @(negedge clk); #1;
            chk("slowb_addr_ok", 64'(addr_ok), 64'(1'b0));
            chk("slowb_data_ok", 64'(data_ok), 64'(t == dok_at));
        end
        @(negedge clk); #1;
        chk("slowb_idle_addr_ok", 64'(addr_ok), 64'(1'b1));
        chk("slowb_idle_data_ok", 64'(data_ok), 64'(1'b0));
        ben = 4'b0000;
        wait_done();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
